aes_keygen_multi: RTL and testbench
===================================

Name: aes_keygen_multi

Overview:
- Parametrised successor to the fixed AES-128 serial key expander; supports AES-128, AES-192 and AES-256, selected at load time.
- Key is shifted in IN_W bits per beat, LSB first, then expanded one 32-bit word per clock into internal word storage.
- Round keys are read back through an indexed, registered port.
- Sits between the key-loading interface and the cipher/decipher round datapaths.

Parameters:
IN_W, 1, serial key bits per accepted beat; legal values 1,2,4,8,16,32,64 (must divide 128, 192 and 256)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
key_len  input  2  2'b00=128, 2'b01=192, 2'b10=256, 2'b11 reserved; sampled on first accepted beat
k_valid  input  1  K_IN beat valid
K_IN  input  IN_W  key bits, LSB first; K_IN[0] is the earliest bit
k_ready  output  1  beat accepted when k_valid&&k_ready
busy  output  1  expansion in progress
done  output  1  all round keys valid
err  output  1  one-cycle pulse on reserved key_len
nr  output  4  round count of loaded key: 10/12/14
rk_sel  input  4  round-key index 0..nr
rk_out  output  128  round key rk_sel, registered

Behaviour:
- Reset (async, reset_n=0): state IDLE; k_ready=1, busy=0, done=0, err=0, nr=0, rk_out=0; beat and word counters cleared. Word storage contents need not be reset.
- Key mapping: the loaded value K[Nk*32-1:0] has bit 0 as the first bit received. Word w0 = K[Nk*32-1 -: 32], descending from there (FIPS hex order). Nk = 4/6/8.
- IDLE:
  - On k_valid with key_len != 11: latch mode, set nr, store the first beat, go to LOAD. If Nk*32/IN_W == 1, go directly to EXPAND.
  - On k_valid with key_len == 11: err=1 for one cycle, beat dropped, stay in IDLE.
- LOAD:
  - k_ready=1. Count accepted beats; idle cycles (k_valid=0) are allowed and hold the count.
  - After beat Nk*32/IN_W, words w0..w(Nk-1) are written and the block goes to EXPAND.
  - key_len is ignored after the first beat.
- EXPAND:
  - k_ready=0, busy=1. One word per cycle for i = Nk .. 4*(nr+1)-1: w[i] = w[i-Nk] ^ t.
  - t = SubWord(RotWord(w[i-1])) ^ Rcon when i mod Nk == 0.
  - t = SubWord(w[i-1]) when Nk == 8 and i mod 8 == 4.
  - Otherwise t = w[i-1].
  - Rcon starts at 0x01 in the top byte and advances by xtime after each use.
  - Four combinational S-box lookups are used; the team S-box module may be reused.
  - Cycle count: 40 / 46 / 52 for 128 / 192 / 256.
- DONE:
  - Entered the cycle after the last word is written: busy=0, done=1, k_ready=1.
  - A k_valid here starts a new load exactly as from IDLE. done drops on that accepting cycle; nr updates to the new mode.
- k_valid during EXPAND is ignored; no beat is consumed.
- Read port:
  - rk_out <= {w[4r], w[4r+1], w[4r+2], w[4r+3]} with r = rk_sel; w[4r] sits at [127:96]. One-cycle latency.
  - rk_out <= 0 when done=0 or rk_sel > nr.
- Reset asserted mid-LOAD or mid-EXPAND returns the block to IDLE immediately. The next load begins cleanly with no stale beat count.

Test Plan:
- IN_W=1, AES-128, key 2b7e151628aed2a6abf7158809cf4f3c fed as 128 contiguous beats:
  - done rises 40 cycles after the last beat; nr=10.
  - rk_sel=0 -> 2b7e151628aed2a6abf7158809cf4f3c.
  - rk_sel=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rk_sel=11 -> 0.
- IN_W=8, AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, with 3 random idle gaps:
  - 24 beats accepted; done 46 cycles after the last beat; nr=12.
  - rk_sel=12 -> e98ba06f448c773c8ecc720401002202.
- IN_W=32, AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - 8 beats; nr=14.
  - rk_sel=14 -> fe4890d1e6188d0b046df344706c631e.
  - rk_sel=1 -> 1f352c073b6108d72d9810a30914dff4.
- key_len=11 with k_valid in IDLE:
  - err pulses for 1 cycle; state stays IDLE; a following valid AES-128 load completes normally.
- Protocol and reset:
  - k_valid held high through EXPAND: k_ready=0 and no beats consumed; the result still matches test 1.
  - reset_n pulsed low at beat 60 of a load: all outputs return to reset values at once.
  - A subsequent full reload yields the correct keys.
- Back-to-back reload:
  - From DONE(AES-256), a new AES-128 load drops done on the first accepted beat; nr becomes 10.
  - The final keys match test 1.

Source files
------------

// File: rtl/aes_keygen_multi.sv
// AES-128/192/256 key expander: LSB-first serial key load, one expanded word per
// clock into local word storage, and a registered indexed round-key read port.
module aes_keygen_multi #(
  parameter int IN_W = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      key_len,
  input  logic            k_valid,
  input  logic [IN_W-1:0] K_IN,
  output logic            k_ready,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [3:0]      nr,
  input  logic [3:0]      rk_sel,
  output logic [127:0]    rk_out
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND, S_DONE} state_t;

  localparam logic [8:0] BEATS_128 = 9'(128 / IN_W);
  localparam logic [8:0] BEATS_192 = 9'(192 / IN_W);
  localparam logic [8:0] BEATS_256 = 9'(256 / IN_W);

  function automatic logic [5:0] nk_of(input logic [1:0] m);
    case (m)
      2'b01:   return 6'd6;
      2'b10:   return 6'd8;
      default: return 6'd4;
    endcase
  endfunction

  function automatic logic [2:0] nk_m1_of(input logic [1:0] m);
    case (m)
      2'b01:   return 3'd5;
      2'b10:   return 3'd7;
      default: return 3'd3;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] m);
    case (m)
      2'b01:   return 4'd12;
      2'b10:   return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  // Index of the final expanded word, 4*(nr+1)-1.
  function automatic logic [5:0] last_of(input logic [1:0] m);
    case (m)
      2'b01:   return 6'd51;
      2'b10:   return 6'd59;
      default: return 6'd43;
    endcase
  endfunction

  function automatic logic [8:0] beats_of(input logic [1:0] m);
    case (m)
      2'b01:   return BEATS_192;
      2'b10:   return BEATS_256;
      default: return BEATS_128;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, which maps 0 to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x3, x7, x15, x31, x63, x127, inv;
    x3   = gf_mul(gf_mul(x, x), x);
    x7   = gf_mul(gf_mul(x3, x3), x);
    x15  = gf_mul(gf_mul(x7, x7), x);
    x31  = gf_mul(gf_mul(x15, x15), x);
    x63  = gf_mul(gf_mul(x31, x31), x);
    x127 = gf_mul(gf_mul(x63, x63), x);
    inv  = gf_mul(x127, x127);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  state_t       r_state;
  logic [1:0]   r_mode;
  logic [8:0]   r_beat;
  logic [255:0] r_key;
  logic [5:0]   r_i;
  logic [2:0]   r_mod;
  logic [7:0]   r_rcon;
  // Power-of-two depth keeps every 6-bit word index in range; words 60..63 are unused.
  logic [31:0]  r_w [0:63];

  logic         w_start;
  logic         w_start_ok;
  logic         w_accept;
  logic         w_last_beat;
  logic [1:0]   w_mode_eff;
  logic [7:0]   w_off;
  logic [255:0] w_key_merged;
  logic [31:0]  w_prev;
  logic [31:0]  w_back;
  logic [31:0]  w_sub_in;
  logic [31:0]  w_sub;
  logic [31:0]  w_t;
  logic [31:0]  w_new_word;
  logic [5:0]   w_rk_base;

  assign w_start     = (r_state == S_IDLE || r_state == S_DONE) && k_valid;
  assign w_start_ok  = w_start && (key_len != 2'b11);
  assign w_accept    = w_start_ok || (r_state == S_LOAD && k_valid);
  assign w_mode_eff  = (r_state == S_LOAD) ? r_mode : key_len;
  assign w_last_beat = w_accept && ((r_beat + 9'd1) == beats_of(w_mode_eff));
  assign w_off       = 8'(32'(r_beat) * IN_W);
  assign w_rk_base   = {rk_sel, 2'b00};

  // NOTE: every always_comb output gets a full default first so no latch is inferred.
  always_comb begin
    w_key_merged = r_key;
    w_key_merged[w_off +: IN_W] = K_IN;
  end

  always_comb begin
    w_prev   = r_w[r_i - 6'd1];
    w_back   = r_w[r_i - nk_of(r_mode)];
    w_sub_in = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    w_sub    = {sbox(w_sub_in[31:24]), sbox(w_sub_in[23:16]),
                sbox(w_sub_in[15:8]),  sbox(w_sub_in[7:0])};
    w_t      = w_prev;
    if (r_mod == 3'd0)
      w_t = w_sub ^ {r_rcon, 24'h000000};
    else if (r_mode == 2'b10 && r_mod == 3'd4)
      w_t = w_sub;
    w_new_word = w_back ^ w_t;
  end

  // NOTE: word storage carries no reset; done gates every read until it is rewritten.
  always_ff @(posedge clk) begin
    if (w_last_beat) begin
      case (w_mode_eff)
        2'b01:   for (int k = 0; k < 6; k++) r_w[k] <= w_key_merged[191 - 32*k -: 32];
        2'b10:   for (int k = 0; k < 8; k++) r_w[k] <= w_key_merged[255 - 32*k -: 32];
        default: for (int k = 0; k < 4; k++) r_w[k] <= w_key_merged[127 - 32*k -: 32];
      endcase
    end else if (r_state == S_EXPAND) begin
      r_w[r_i] <= w_new_word;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      k_ready <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      nr      <= 4'd0;
      r_mode  <= 2'b00;
      r_beat  <= 9'd0;
      r_key   <= '0;
      r_i     <= 6'd0;
      r_mod   <= 3'd0;
      r_rcon  <= 8'h00;
    end else begin
      err <= w_start && (key_len == 2'b11);
      case (r_state)
        S_EXPAND: begin
          if (r_i == last_of(r_mode)) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            k_ready <= 1'b1;
          end
          r_i   <= r_i + 6'd1;
          r_mod <= (r_mod == nk_m1_of(r_mode)) ? 3'd0 : r_mod + 3'd1;
          if (r_mod == 3'd0) r_rcon <= xtime(r_rcon);
        end
        default: begin
          if (w_start_ok) begin
            r_mode <= key_len;
            nr     <= nr_of(key_len);
            done   <= 1'b0;
          end
          if (w_accept) begin
            r_key <= w_key_merged;
            if (w_last_beat) begin
              r_state <= S_EXPAND;
              k_ready <= 1'b0;
              busy    <= 1'b1;
              r_beat  <= 9'd0;
              r_i     <= nk_of(w_mode_eff);
              r_mod   <= 3'd0;
              r_rcon  <= 8'h01;
            end else begin
              r_state <= S_LOAD;
              r_beat  <= r_beat + 9'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rk_out <= '0;
    else if (!done || (rk_sel > nr))
      rk_out <= '0;
    else
      rk_out <= {r_w[w_rk_base], r_w[w_rk_base + 6'd1],
                 r_w[w_rk_base + 6'd2], r_w[w_rk_base + 6'd3]};
  end

endmodule

// File: tb/tb_aes_keygen_multi.sv
// Directed bench for aes_keygen_multi using FIPS-197 key-expansion vectors at
// serial widths 1, 8 and 32.
module tb_aes_keygen_multi;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [1:0]   kl_a, kl_b, kl_c;
  logic         kv_a, kv_b, kv_c;
  logic [0:0]   kin_a;
  logic [7:0]   kin_b;
  logic [31:0]  kin_c;
  logic         kr_a, kr_b, kr_c;
  logic         bz_a, bz_b, bz_c;
  logic         dn_a, dn_b, dn_c;
  logic         er_a, er_b, er_c;
  logic [3:0]   nr_a, nr_b, nr_c;
  logic [3:0]   sel_a, sel_b, sel_c;
  logic [127:0] rko_a, rko_b, rko_c;

  aes_keygen_multi #(.IN_W(1)) u_dut_w1 (
    .clk(clk), .reset_n(reset_n), .key_len(kl_a), .k_valid(kv_a), .K_IN(kin_a),
    .k_ready(kr_a), .busy(bz_a), .done(dn_a), .err(er_a), .nr(nr_a),
    .rk_sel(sel_a), .rk_out(rko_a));

  aes_keygen_multi #(.IN_W(8)) u_dut_w8 (
    .clk(clk), .reset_n(reset_n), .key_len(kl_b), .k_valid(kv_b), .K_IN(kin_b),
    .k_ready(kr_b), .busy(bz_b), .done(dn_b), .err(er_b), .nr(nr_b),
    .rk_sel(sel_b), .rk_out(rko_b));

  aes_keygen_multi #(.IN_W(32)) u_dut_w32 (
    .clk(clk), .reset_n(reset_n), .key_len(kl_c), .k_valid(kv_c), .K_IN(kin_c),
    .k_ready(kr_c), .busy(bz_c), .done(dn_c), .err(er_c), .nr(nr_c),
    .rk_sel(sel_c), .rk_out(rko_c));

  localparam logic [255:0] KEY128 = {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
  localparam logic [255:0] KEY192 = {64'h0, 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] RK256_14 = 128'hfe4890d1e6188d0b046df344706c631e;
  localparam logic [127:0] RK256_1  = 128'h1f352c073b6108d72d9810a30914dff4;

  int n_pass  = 0;
  int n_total = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    kv_a = 1'b0; kv_b = 1'b0; kv_c = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic feed_a(input logic [255:0] key, input int nbits, input logic [1:0] len,
                        input bit hold);
    logic [255:0] k;
    k = key;
    for (int j = 0; j < nbits; j++) begin
      kv_a  = 1'b1;
      kl_a  = len;
      kin_a = k[j];
      tick();
    end
    if (!hold) kv_a = 1'b0;
  endtask

  task automatic feed_c(input logic [255:0] key, input int first, input int last,
                        input logic [1:0] len);
    logic [255:0] k;
    k = key;
    for (int j = first; j < last; j++) begin
      kv_c  = 1'b1;
      kl_c  = len;
      kin_c = k[32*j +: 32];
      tick();
    end
    kv_c = 1'b0;
  endtask

  // Cycles from the current point until done is seen; -1 if the budget expires.
  task automatic wait_done(input int which, output int cyc);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      tick();
      n++;
      seen = (which == 0) ? dn_a : (which == 1) ? dn_b : dn_c;
    end
    cyc = seen ? n : -1;
  endtask

  task automatic read_rk(input int which, input logic [3:0] sel, output logic [127:0] v);
    if (which == 0) sel_a = sel;
    else if (which == 1) sel_b = sel;
    else sel_c = sel;
    tick();
    v = (which == 0) ? rko_a : (which == 1) ? rko_b : rko_c;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    n_total++;
    if (kr_a !== 1'b1) $display("FAIL reset_k_ready: got %b want 1", kr_a); else n_pass++;
    n_total++;
    if (bz_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", bz_a); else n_pass++;
    n_total++;
    if (dn_a !== 1'b0) $display("FAIL reset_done: got %b want 0", dn_a); else n_pass++;
    n_total++;
    if (er_a !== 1'b0) $display("FAIL reset_err: got %b want 0", er_a); else n_pass++;
    n_total++;
    if (nr_a !== 4'd0) $display("FAIL reset_nr: got %0d want 0", nr_a); else n_pass++;
    n_total++;
    if (rko_c !== 128'h0) $display("FAIL reset_rk_out: got %h want 0", rko_c); else n_pass++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_aes128();
    int cyc;
    logic [127:0] v;
    feed_a(KEY128, 128, 2'b00, 1'b0);
    n_total++;
    if ({bz_a, kr_a} !== 2'b10) $display("FAIL aes128_expand_flags: got %b want 10", {bz_a, kr_a});
    else n_pass++;
    wait_done(0, cyc);
    n_total++;
    if (cyc !== 40) $display("FAIL aes128_latency: got %0d want 40", cyc); else n_pass++;
    n_total++;
    if (nr_a !== 4'd10) $display("FAIL aes128_nr: got %0d want 10", nr_a); else n_pass++;
    read_rk(0, 4'd0, v);
    n_total++;
    if (v !== RK128_0) $display("FAIL aes128_rk0: got %h want %h", v, RK128_0); else n_pass++;
    read_rk(0, 4'd10, v);
    n_total++;
    if (v !== RK128_10) $display("FAIL aes128_rk10: got %h want %h", v, RK128_10); else n_pass++;
    read_rk(0, 4'd11, v);
    n_total++;
    if (v !== 128'h0) $display("FAIL aes128_rk11: got %h want 0", v); else n_pass++;
  endtask

  task automatic test_aes192();
    int cyc;
    int acc;
    logic [255:0] k;
    logic [127:0] v;
    k   = KEY192;
    acc = 0;
    for (int j = 0; j < 24; j++) begin
      if (j == 5 || j == 12 || j == 20) begin
        kv_b = 1'b0;
        repeat ($urandom_range(3, 1)) tick();
      end
      kv_b  = 1'b1;
      kl_b  = 2'b01;
      kin_b = k[8*j +: 8];
      if (kr_b) acc++;
      tick();
    end
    kv_b = 1'b0;
    n_total++;
    if (acc !== 24) $display("FAIL aes192_beats: got %0d want 24", acc); else n_pass++;
    wait_done(1, cyc);
    n_total++;
    if (cyc !== 46) $display("FAIL aes192_latency: got %0d want 46", cyc); else n_pass++;
    n_total++;
    if (nr_b !== 4'd12) $display("FAIL aes192_nr: got %0d want 12", nr_b); else n_pass++;
    read_rk(1, 4'd12, v);
    n_total++;
    if (v !== RK192_12) $display("FAIL aes192_rk12: got %h want %h", v, RK192_12); else n_pass++;
  endtask

  task automatic test_aes256();
    int cyc;
    logic [127:0] v;
    feed_c(KEY256, 0, 8, 2'b10);
    wait_done(2, cyc);
    n_total++;
    if (cyc !== 52) $display("FAIL aes256_latency: got %0d want 52", cyc); else n_pass++;
    n_total++;
    if (nr_c !== 4'd14) $display("FAIL aes256_nr: got %0d want 14", nr_c); else n_pass++;
    read_rk(2, 4'd14, v);
    n_total++;
    if (v !== RK256_14) $display("FAIL aes256_rk14: got %h want %h", v, RK256_14); else n_pass++;
    read_rk(2, 4'd1, v);
    n_total++;
    if (v !== RK256_1) $display("FAIL aes256_rk1: got %h want %h", v, RK256_1); else n_pass++;
  endtask

  task automatic test_err();
    int cyc;
    logic [127:0] v;
    apply_reset();
    kl_a  = 2'b11;
    kv_a  = 1'b1;
    kin_a = 1'b1;
    tick();
    kv_a = 1'b0;
    kl_a = 2'b00;
    n_total++;
    if (er_a !== 1'b1) $display("FAIL err_pulse: got %b want 1", er_a); else n_pass++;
    n_total++;
    if ({kr_a, bz_a, dn_a, nr_a} !== {1'b1, 1'b0, 1'b0, 4'd0})
      $display("FAIL err_idle_state: got %b want 1000000", {kr_a, bz_a, dn_a, nr_a});
    else n_pass++;
    tick();
    n_total++;
    if (er_a !== 1'b0) $display("FAIL err_one_cycle: got %b want 0", er_a); else n_pass++;
    feed_a(KEY128, 128, 2'b00, 1'b0);
    wait_done(0, cyc);
    n_total++;
    if (cyc !== 40) $display("FAIL err_reload_latency: got %0d want 40", cyc); else n_pass++;
    read_rk(0, 4'd10, v);
    n_total++;
    if (v !== RK128_10) $display("FAIL err_reload_rk10: got %h want %h", v, RK128_10); else n_pass++;
  endtask

  task automatic test_valid_through_expand();
    int  n;
    int  viol;
    bit  seen;
    logic [127:0] v;
    feed_a(KEY128, 128, 2'b00, 1'b1);
    viol = (kr_a !== 1'b0) ? 1 : 0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      kin_a = n[0];
      tick();
      n++;
      if (dn_a) begin
        seen = 1'b1;
        kv_a = 1'b0;
      end else if (kr_a !== 1'b0) begin
        viol++;
      end
    end
    kv_a = 1'b0;
    n_total++;
    if (viol !== 0) $display("FAIL hold_ready_low: got %0d ready cycles want 0", viol); else n_pass++;
    n_total++;
    if (n !== 40) $display("FAIL hold_latency: got %0d want 40", n); else n_pass++;
    read_rk(0, 4'd10, v);
    n_total++;
    if (v !== RK128_10) $display("FAIL hold_rk10: got %h want %h", v, RK128_10); else n_pass++;
    read_rk(0, 4'd0, v);
    n_total++;
    if (v !== RK128_0) $display("FAIL hold_rk0: got %h want %h", v, RK128_0); else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    int cyc;
    logic [127:0] v;
    feed_a(KEY128, 60, 2'b00, 1'b1);
    n_total++;
    if ({dn_a, bz_a, nr_a} !== {1'b0, 1'b0, 4'd10})
      $display("FAIL midload_state: got %b want 001010", {dn_a, bz_a, nr_a});
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_total++;
    if (kr_a !== 1'b1) $display("FAIL midreset_k_ready: got %b want 1", kr_a); else n_pass++;
    n_total++;
    if (bz_a !== 1'b0) $display("FAIL midreset_busy: got %b want 0", bz_a); else n_pass++;
    n_total++;
    if (dn_a !== 1'b0) $display("FAIL midreset_done: got %b want 0", dn_a); else n_pass++;
    n_total++;
    if (er_a !== 1'b0) $display("FAIL midreset_err: got %b want 0", er_a); else n_pass++;
    n_total++;
    if (nr_a !== 4'd0) $display("FAIL midreset_nr: got %0d want 0", nr_a); else n_pass++;
    n_total++;
    if (rko_a !== 128'h0) $display("FAIL midreset_rk_out: got %h want 0", rko_a); else n_pass++;
    kv_a = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    feed_a(KEY128, 128, 2'b00, 1'b0);
    wait_done(0, cyc);
    n_total++;
    if (cyc !== 40) $display("FAIL midreset_reload_latency: got %0d want 40", cyc); else n_pass++;
    read_rk(0, 4'd10, v);
    n_total++;
    if (v !== RK128_10) $display("FAIL midreset_rk10: got %h want %h", v, RK128_10); else n_pass++;
    read_rk(0, 4'd0, v);
    n_total++;
    if (v !== RK128_0) $display("FAIL midreset_rk0: got %h want %h", v, RK128_0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [127:0] v;
    feed_c(KEY256, 0, 8, 2'b10);
    wait_done(2, cyc);
    n_total++;
    if (cyc !== 52) $display("FAIL b2b_first_latency: got %0d want 52", cyc); else n_pass++;
    feed_c(KEY128, 0, 1, 2'b00);
    n_total++;
    if ({dn_c, nr_c} !== {1'b0, 4'd10})
      $display("FAIL b2b_done_nr: got %b want 01010", {dn_c, nr_c});
    else n_pass++;
    n_total++;
    if (kr_c !== 1'b1) $display("FAIL b2b_ready_in_load: got %b want 1", kr_c); else n_pass++;
    feed_c(KEY128, 1, 4, 2'b00);
    wait_done(2, cyc);
    n_total++;
    if (cyc !== 40) $display("FAIL b2b_second_latency: got %0d want 40", cyc); else n_pass++;
    read_rk(2, 4'd10, v);
    n_total++;
    if (v !== RK128_10) $display("FAIL b2b_rk10: got %h want %h", v, RK128_10); else n_pass++;
    read_rk(2, 4'd0, v);
    n_total++;
    if (v !== RK128_0) $display("FAIL b2b_rk0: got %h want %h", v, RK128_0); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    kl_a = 2'b00; kl_b = 2'b00; kl_c = 2'b00;
    kv_a = 1'b0;  kv_b = 1'b0;  kv_c = 1'b0;
    kin_a = '0;   kin_b = '0;   kin_c = '0;
    sel_a = 4'd0; sel_b = 4'd0; sel_c = 4'd0;
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_err();
    test_valid_through_expand();
    test_reset_mid_load();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
